// File: rtl/microwave_timer_ctrl_pkg.sv
// microwave_timer_ctrl_pkg: shared states, BCD digit type and digit limits for the microwave timer controller
package microwave_timer_ctrl_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic [2:0] {IDLE, LD_SO, LD_ST, LD_MIN, COOK, PAUSE, DONE, CLR} state_t;
  localparam bcd_t MAX_DIGIT = 4'd9;
  localparam bcd_t MAX_SEC_TENS = 4'd5;
  function automatic bcd_t clamp_st(bcd_t d);
    return (d > MAX_SEC_TENS) ? MAX_SEC_TENS : d;
  endfunction
endpackage

// File: rtl/microwave_timer_ctrl_entry_shift_reg.sv
// entry_shift_reg: 3-digit BCD keypad entry register; non-BCD digits are dropped
module entry_shift_reg
  import microwave_timer_ctrl_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic clr,
  input  logic shift,
  input  bcd_t digit,
  output bcd_t so,
  output bcd_t st,
  output bcd_t mn,
  output logic nonzero
);
  always_ff @(posedge clk)
    if (clear || clr) {mn, st, so} <= '0;
    else if (shift && digit <= MAX_DIGIT) {mn, st, so} <= {st, so, digit};
  assign nonzero = |{mn, st, so};
endmodule

// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad entry, timer load sequencing and cook/pause/done FSM
// Optional `DONE_BEEP_EN adds the beep output held for BEEP_TICKS ticks after cooking completes.
module microwave_timer_ctrl
  import microwave_timer_ctrl_pkg::*;
`ifdef DONE_BEEP_EN
  #(parameter int BEEP_TICKS = 3)
`endif
(
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       cancel,
  input  logic       door_closed,
  input  logic       tick,
  input  logic       timer_zero,
  output logic [3:0] timer_data,
  output logic       load_so,
  output logic       load_st,
  output logic       load_min,
  output logic       timer_enable,
  output logic       timer_clearn,
  output logic       mag_on,
`ifdef DONE_BEEP_EN
  output logic       beep,
`endif
  output logic       done
);
  state_t state, next_state;
  bcd_t ent_so, ent_st, ent_min;
  logic ent_nz, shift, ent_clr;
  entry_shift_reg u_entry (
    .clk(clk), .clear(clear), .clr(ent_clr), .shift(shift), .digit(key_digit),
    .so(ent_so), .st(ent_st), .mn(ent_min), .nonzero(ent_nz)
  );
  always_comb begin
    next_state = state;
    shift = 1'b0;
    case (state)
      IDLE: begin
        next_state = cancel ? CLR : (start && door_closed && ent_nz) ? LD_SO : IDLE;
        shift = key_valid && !cancel && !stop && !start;
      end
      LD_SO:  next_state = (cancel || !door_closed) ? CLR : LD_ST;
      LD_ST:  next_state = (cancel || !door_closed) ? CLR : LD_MIN;
      LD_MIN: next_state = (cancel || !door_closed) ? CLR : COOK;
      COOK:   next_state = cancel ? CLR : timer_zero ? DONE : (!door_closed || stop) ? PAUSE : COOK;
      PAUSE:  next_state = cancel ? CLR : (start && door_closed) ? COOK : PAUSE;
      DONE:   next_state = (start || cancel || key_valid || !door_closed) ? IDLE : DONE;
      CLR:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    ent_clr = (next_state == DONE) || (next_state == CLR);
  end
  assign timer_enable = (state == COOK) && tick && door_closed;
  // Moore outputs are decoded from next_state so they change in the same edge as the state
  always_ff @(posedge clk)
    if (clear) begin
      state <= IDLE;
      timer_data <= '0;
      {load_so, load_st, load_min} <= '0;
      mag_on <= 1'b0;
      done <= 1'b0;
      timer_clearn <= 1'b0;
    end else begin
      state <= next_state;
      timer_data <= (next_state == LD_SO) ? ent_so : (next_state == LD_ST) ? clamp_st(ent_st) :
                    (next_state == LD_MIN) ? ent_min : '0;
      load_so <= next_state == LD_SO;
      load_st <= next_state == LD_ST;
      load_min <= next_state == LD_MIN;
      mag_on <= next_state == COOK;
      done <= next_state == DONE;
      timer_clearn <= next_state != CLR;
    end
`ifdef DONE_BEEP_EN
  localparam int CW = $clog2(BEEP_TICKS + 1);
  localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_TICKS - 1);
  logic [CW-1:0] beep_cnt;
  always_ff @(posedge clk)
    if (clear || next_state != DONE) begin
      beep <= 1'b0;
      beep_cnt <= '0;
    end else if (state != DONE) begin
      beep <= 1'b1;
      beep_cnt <= '0;
    end else if (beep && tick) begin
      beep_cnt <= beep_cnt + CW'(1);
      beep <= beep_cnt != BEEP_LAST;
    end
`endif
endmodule
